// File: rtl/cmp_crossing_detector.sv
// Hold-count hysteresis filter on comparator gt/lt/eq flags with crossing pulses and counters.
// Optional macro CMP_XDET_CLR_EN adds a synchronous cnt_clr input for the crossing counters.
module cmp_crossing_detector #(
  parameter int HOLD_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
`ifdef CMP_XDET_CLR_EN
  input  logic             cnt_clr,
`endif
  output logic [1:0]       state,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             err,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count
);

  localparam int RUN_W = (HOLD_CNT < 1) ? 1 : $clog2(HOLD_CNT + 1);
  localparam logic [RUN_W-1:0] HOLD_V = RUN_W'(HOLD_CNT);
  localparam logic [1:0] ST_UNKNOWN = 2'b00;

  logic [1:0]       r_state, r_cand;
  logic [RUN_W-1:0] r_run;
  logic             r_rise, r_fall, r_err;
  logic [CNT_W-1:0] r_rise_cnt, r_fall_cnt;

  logic [1:0]       w_state_nxt, w_cand_nxt, w_cls;
  logic [RUN_W-1:0] w_run_nxt, w_n;
  logic             w_legal, w_commit;
  logic             w_rise_nxt, w_fall_nxt, w_err_nxt;
  logic             w_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Exactly one flag high; class encoding doubles as rank (BELOW<EQUAL<ABOVE).
  assign w_legal = (gt ^ lt ^ eq) & ~(gt & lt & eq);
  assign w_cls   = lt ? 2'b01 : (eq ? 2'b10 : 2'b11);
  assign w_n     = (w_cls == r_cand) ? r_run + 1'b1 : RUN_W'(1);

`ifdef CMP_XDET_CLR_EN
  assign w_clr = cnt_clr;
`else
  assign w_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNKNOWN;
      r_cand     <= ST_UNKNOWN;
      r_run      <= '0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_err      <= 1'b0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_run   <= w_run_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_err   <= w_err_nxt;
      if (w_clr) begin
        r_rise_cnt <= '0;
        r_fall_cnt <= '0;
      end else begin
        if (w_rise_nxt) r_rise_cnt <= sat_inc(r_rise_cnt);
        if (w_fall_nxt) r_fall_cnt <= sat_inc(r_fall_cnt);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_run_nxt   = r_run;
    w_commit    = 1'b0;
    if (in_valid) begin
      if (!w_legal || (w_cls == r_state)) begin
        w_cand_nxt = r_state;
        w_run_nxt  = '0;
      end else begin
        w_cand_nxt = w_cls;
        if (w_n == HOLD_V) begin
          w_commit    = 1'b1;
          w_state_nxt = w_cls;
          w_run_nxt   = '0;
        end else begin
          w_run_nxt = w_n;
        end
      end
    end
  end

  // Leaving UNKNOWN is a first lock, not a crossing: no pulse.
  always_comb begin
    w_err_nxt  = in_valid & ~w_legal;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (w_commit && (r_state != ST_UNKNOWN)) begin
      w_rise_nxt = (w_cls > r_state);
      w_fall_nxt = (w_cls < r_state);
    end
  end

  assign state      = r_state;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign err        = r_err;
  assign rise_count = r_rise_cnt;
  assign fall_count = r_fall_cnt;

endmodule
